edge_loader: RTL and testbench

Byte-stream configuration loader for the pulse generator: it is the writer of the edge table that the pulse logic reads. It receives framed commands over a valid/ready byte interface and assembles 68-bit edge records into the flat `eds` bus. It also loads `period`, `outer_period` and `state0`, and holds the pulse generator in reset until the host commits. Every command is answered with a one-byte acknowledge on a second valid/ready stream.

---
 rtl/edge_loader_pkg.sv | 50 +++++
 rtl/edge_loader_shreg.sv | 34 +++
 rtl/edge_loader.sv | 267 ++++++++++++++++++++++++++
 tb/tb_edge_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_loader_pkg                                                      |
// | Opcodes, ack codes, FSM state encodings and payload sizing.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package edge_loader_pkg;

  localparam int ED_BITS    = 68;
  localparam int EDGE_BYTES = (ED_BITS + 7) / 8;
  localparam int SHREG_BITS = EDGE_BYTES * 8;

  localparam logic [7:0] OP_WRITE_EDGE   = 8'h01;
  localparam logic [7:0] OP_WRITE_PERIOD = 8'h02;
  localparam logic [7:0] OP_WRITE_OUTER  = 8'h03;
  localparam logic [7:0] OP_WRITE_STATE0 = 8'h04;
  localparam logic [7:0] OP_COMMIT       = 8'h05;
  localparam logic [7:0] OP_CLEAR        = 8'h06;

  localparam logic [7:0] ACK_OK_BASE   = 8'hA0;
  localparam logic [7:0] ACK_BAD_OP    = 8'hE1;
  localparam logic [7:0] ACK_BAD_INDEX = 8'hE2;
  localparam logic [7:0] ACK_BAD_CSUM  = 8'hE3;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INDEX   = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_APPLY   = 3'd4;
  localparam logic [2:0] ST_ACK     = 3'd5;

  // Record bytes following the opcode (the edge index byte is not counted).
  function automatic logic [3:0] payload_len(input logic [7:0] op);
    case (op)
      OP_WRITE_EDGE:   payload_len = 4'(EDGE_BYTES);
      OP_WRITE_PERIOD: payload_len = 4'd4;
      OP_WRITE_OUTER:  payload_len = 4'd4;
      OP_WRITE_STATE0: payload_len = 4'd1;
      default:         payload_len = 4'd0;
    endcase
  endfunction

  function automatic logic op_known(input logic [7:0] op);
    op_known = (op >= OP_WRITE_EDGE) && (op <= OP_CLEAR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_loader_shreg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_loader_shreg                                                    |
// | Little-endian byte assembler: each byte enters at the top, so an     |
// | N-byte value ends up in the upper N bytes of data_o.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module edge_loader_shreg
  import edge_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [7:0]            byte_i,
  output logic [SHREG_BITS-1:0] data_o
);

  logic [SHREG_BITS-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= {byte_i, data_q[SHREG_BITS-1:8]};
    end
  end

  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/edge_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_loader                                                          |
// | Framed byte-stream loader for the pulse generator edge table,        |
// | periods and initial state. Optional: EDGE_LOADER_CHECKSUM_EN adds a  |
// | trailing XOR checksum byte to every command.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module edge_loader
  import edge_loader_pkg::*;
#(
  parameter int COUNT_BITS = 32,
  parameter int CH_LOG2    = 3,
  parameter int ED_MAX     = 255
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [7:0]                                    in_data,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  output logic [7:0]                                    ack_data,
  output logic                                          ack_valid,
  input  logic                                          ack_ready,
  output logic [(2*COUNT_BITS+CH_LOG2+1)*ED_MAX-1:0]    eds,
  output logic [COUNT_BITS-1:0]                         period,
  output logic [COUNT_BITS-1:0]                         outer_period,
  output logic [7:0]                                    state0,
  output logic                                          pg_reset
);

  localparam int ED_W = 2*COUNT_BITS + CH_LOG2 + 1;

`ifdef EDGE_LOADER_CHECKSUM_EN
  localparam state_t ST_TAIL = ST_CHECK;
`else
  localparam state_t ST_TAIL = ST_APPLY;
`endif

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             op_q, op_d;
  logic [7:0]             idx_q, idx_d;
  logic [7:0]             ack_data_q, ack_data_d;
  logic [COUNT_BITS-1:0]  period_q, outer_q;
  logic [7:0]             state0_q;
  logic                   pg_reset_q;

  logic                   w_accept;
  logic                   w_shreg_clr;
  logic                   w_shreg_load;
  logic [SHREG_BITS-1:0]  w_payload;
  logic                   w_idx_bad;
  logic                   w_csum_bad;
  logic                   w_ok;
  logic                   w_apply;
  logic                   w_wr_edge;
  logic                   w_clear;
  logic [7:0]             w_ack_code;

`ifdef EDGE_LOADER_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
  logic                   csum_err_q, csum_err_d;
  assign w_csum_bad = csum_err_q;
`else
  assign w_csum_bad = 1'b0;
`endif

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_INDEX) ||
                     (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
  assign w_accept  = in_valid & in_ready;
  assign ack_valid = (state_q == ST_ACK);
  assign ack_data  = ack_data_q;

  assign w_shreg_clr  = w_accept && (state_q == ST_IDLE);
  assign w_shreg_load = w_accept && (state_q == ST_PAYLOAD);

  edge_loader_shreg u_shreg (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (w_shreg_clr),
    .load_i (w_shreg_load),
    .byte_i (in_data),
    .data_o (w_payload)
  );

  // Index byte is 8 bits wide while ED_MAX may reach 256, hence the extra bit.
  assign w_idx_bad = (op_q == OP_WRITE_EDGE) && ({1'b0, idx_q} >= 9'(ED_MAX));
  assign w_ok      = op_known(op_q) && !w_csum_bad && !w_idx_bad;
  assign w_apply   = (state_q == ST_APPLY) && w_ok;
  assign w_wr_edge = w_apply && (op_q == OP_WRITE_EDGE);
  assign w_clear   = w_apply && (op_q == OP_CLEAR);

  always_comb begin
    if (!op_known(op_q)) begin
      w_ack_code = ACK_BAD_OP;
    end else if (w_csum_bad) begin
      w_ack_code = ACK_BAD_CSUM;
    end else if (w_idx_bad) begin
      w_ack_code = ACK_BAD_INDEX;
    end else begin
      w_ack_code = ACK_OK_BASE | op_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    idx_d      = idx_q;
    ack_data_d = ack_data_q;
`ifdef EDGE_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    csum_err_d = csum_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          op_d = in_data;
`ifdef EDGE_LOADER_CHECKSUM_EN
          csum_d     = in_data;
          csum_err_d = 1'b0;
`endif
          if (in_data == OP_WRITE_EDGE) begin
            state_d = ST_INDEX;
          end else if (payload_len(in_data) != 4'd0) begin
            state_d = ST_PAYLOAD;
            cnt_d   = payload_len(in_data);
          end else if (op_known(in_data)) begin
            state_d = ST_TAIL;
          end else begin
`ifdef EDGE_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d    = ST_ACK;
            ack_data_d = ACK_BAD_OP;
`endif
          end
        end
      end
      ST_INDEX: begin
        if (w_accept) begin
          idx_d   = in_data;
          cnt_d   = 4'(EDGE_BYTES);
          state_d = ST_PAYLOAD;
`ifdef EDGE_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
        end
      end
      ST_PAYLOAD: begin
        if (w_accept) begin
          cnt_d = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
`ifdef EDGE_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (cnt_q <= 4'd1) begin
            state_d = ST_TAIL;
          end
        end
      end
      ST_CHECK: begin
`ifdef EDGE_LOADER_CHECKSUM_EN
        if (w_accept) begin
          csum_err_d = (in_data != csum_q);
          state_d    = ST_APPLY;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_APPLY: begin
        ack_data_d = w_ack_code;
        state_d    = ST_ACK;
      end
      ST_ACK: begin
        if (ack_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      idx_q      <= '0;
      ack_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      ack_data_q <= ack_data_d;
    end
  end

`ifdef EDGE_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q     <= '0;
      csum_err_q <= 1'b0;
    end else begin
      csum_q     <= csum_d;
      csum_err_q <= csum_err_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q   <= {{(COUNT_BITS-1){1'b0}}, 1'b1};
      outer_q    <= {{(COUNT_BITS-1){1'b0}}, 1'b1};
      state0_q   <= '0;
      pg_reset_q <= 1'b1;
    end else if (w_apply) begin
      case (op_q)
        OP_WRITE_PERIOD: begin
          period_q   <= w_payload[SHREG_BITS-1 -: COUNT_BITS];
          pg_reset_q <= 1'b1;
        end
        OP_WRITE_OUTER: begin
          outer_q    <= w_payload[SHREG_BITS-1 -: COUNT_BITS];
          pg_reset_q <= 1'b1;
        end
        OP_WRITE_STATE0: begin
          state0_q   <= w_payload[SHREG_BITS-1 -: 8];
          pg_reset_q <= 1'b1;
        end
        OP_COMMIT: begin
          pg_reset_q <= 1'b0;
        end
        default: begin
          pg_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign period       = period_q;
  assign outer_period = outer_q;
  assign state0       = state0_q;
  assign pg_reset     = pg_reset_q;

  // One register per slot; the top nibble of record byte 8 is dropped here.
  for (genvar i = 0; i < ED_MAX; i++) begin : g_slot
    logic [ED_W-1:0] slot_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        slot_q <= '0;
      end else if (w_clear) begin
        slot_q <= '0;
      end else if (w_wr_edge && (idx_q == 8'(i))) begin
        slot_q <= w_payload[ED_W-1:0];
      end
    end

    assign eds[i*ED_W +: ED_W] = slot_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_edge_loader                                                       |
// | Directed bench with a command-level reference model for edge_loader. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_edge_loader;

  localparam int ED_MAX = 255;
  localparam int RW     = 68;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        ack_data;
  logic              ack_valid;
  logic              ack_ready;
  logic [RW*ED_MAX-1:0] eds;
  logic [31:0]       period;
  logic [31:0]       outer_period;
  logic [7:0]        state0;
  logic              pg_reset;

  edge_loader #(
    .COUNT_BITS (32),
    .CH_LOG2    (3),
    .ED_MAX     (ED_MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ack_data     (ack_data),
    .ack_valid    (ack_valid),
    .ack_ready    (ack_ready),
    .eds          (eds),
    .period       (period),
    .outer_period (outer_period),
    .state0       (state0),
    .pg_reset     (pg_reset)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model: architectural state and handshake expectations.
  logic [RW-1:0] m_eds [ED_MAX];
  logic [31:0]   m_period, m_outer;
  logic [7:0]    m_state0, m_ack_data;
  logic          m_pg, m_ack_valid, m_in_ready;
  logic [7:0]    last_ack;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_eds();
    int bad;
    bad = -1;
    for (int i = 0; i < ED_MAX; i++)
      if (bad < 0 && eds[i*RW +: RW] !== m_eds[i]) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL eds slot %0d: got %0h expected %0h", bad, eds[bad*RW +: RW], m_eds[bad]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ED_MAX; i++) m_eds[i] = '0;
    m_period    = 32'd1;
    m_outer     = 32'd1;
    m_state0    = 8'h00;
    m_pg        = 1'b1;
    m_ack_valid = 1'b0;
    m_ack_data  = 8'h00;
    m_in_ready  = 1'b1;
  endtask

  // Effect of one complete command, computed from the command bytes alone.
  task automatic model_apply(input logic [7:0] b[$], input bit csum_ok);
    logic [7:0]    op;
    logic [RW-1:0] rec;
    op = b[0];
    if (op < 8'h01 || op > 8'h06) begin
      m_ack_data = 8'hE1;
    end else if (!csum_ok) begin
      m_ack_data = 8'hE3;
    end else begin
      m_ack_data = 8'hA0 + op;
      case (op)
        8'h01: begin
          if (int'(b[1]) >= ED_MAX) begin
            m_ack_data = 8'hE2;
          end else begin
            rec = {b[10][3:0], b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]};
            m_eds[b[1]] = rec;
            m_pg = 1'b1;
          end
        end
        8'h02: begin m_period = {b[4], b[3], b[2], b[1]}; m_pg = 1'b1; end
        8'h03: begin m_outer  = {b[4], b[3], b[2], b[1]}; m_pg = 1'b1; end
        8'h04: begin m_state0 = b[1]; m_pg = 1'b1; end
        8'h05: m_pg = 1'b0;
        default: begin
          for (int i = 0; i < ED_MAX; i++) m_eds[i] = '0;
          m_pg = 1'b1;
        end
      endcase
    end
    m_ack_valid = 1'b1;
  endtask

  // Called at a negedge. Sends the bytes, holds ack_ready low for 'hold'
  // cycles while offering a stray byte, then completes the ack handshake.
  task automatic send_cmd(input logic [7:0] b[$], input logic [7:0] flip, input int hold);
    logic [7:0] q[$];
    bit two_cycle;
    q = b;
`ifdef EDGE_LOADER_CHECKSUM_EN
    begin
      logic [7:0] cs;
      cs = 8'h00;
      foreach (b[k]) cs ^= b[k];
      q.push_back(cs ^ flip);
    end
    two_cycle = 1'b1;
`else
    two_cycle = (b[0] >= 8'h01 && b[0] <= 8'h06);
`endif
    foreach (q[k]) begin
      in_data  = q[k];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid   = 1'b0;
    in_data    = 8'h00;
    m_in_ready = 1'b0;
    if (two_cycle) @(negedge clk);
    model_apply(b, flip == 8'h00);
    last_ack = ack_data;
    if (hold > 0) begin
      in_valid = 1'b1;
      in_data  = 8'h06;
    end
    repeat (hold) @(negedge clk);
    in_valid  = 1'b0;
    ack_ready = 1'b1;
    @(negedge clk);
    ack_ready   = 1'b0;
    m_ack_valid = 1'b0;
    m_in_ready  = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        check("in_ready", in_ready, m_in_ready);
        check("ack_valid", ack_valid, m_ack_valid);
        if (m_ack_valid) check("ack_data", ack_data, m_ack_data);
        check("period", period, m_period);
        check("outer_period", outer_period, m_outer);
        check("state0", state0, m_state0);
        check("pg_reset", pg_reset, m_pg);
        check_eds();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] cmd[$];
    in_data   = 8'h00;
    in_valid  = 1'b0;
    ack_ready = 1'b0;
    reset     = 1'b0;
    last_ack  = 8'h00;
    model_reset();
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst pg_reset", pg_reset, 1'b1);
    check("rst period", period, 32'd1);
    check("rst outer", outer_period, 32'd1);
    check("rst eds zero", |eds, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    check("rst ack_valid", ack_valid, 1'b0);
    check("rst ack_data", ack_data, 8'h00);
    @(negedge clk);

    cmd = '{8'h01, 8'h03, 8'h64, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h08};
    send_cmd(cmd, 8'h00, 0);
    check("edge3 slot", eds[271:204], 68'h8_0000000A_00000064);
    check("edge3 ack", last_ack, 8'hA1);

    cmd = '{8'h02, 8'h64, 8'h00, 8'h00, 8'h00};
    send_cmd(cmd, 8'h00, 0);
    check("period 100", period, 32'd100);
    check("period ack", last_ack, 8'hA2);
    check("pg before commit", pg_reset, 1'b1);

    cmd = '{8'h05};
    send_cmd(cmd, 8'h00, 0);
    check("commit ack", last_ack, 8'hA5);
    check("pg after commit", pg_reset, 1'b0);

    cmd = '{8'h01, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h0F};
    send_cmd(cmd, 8'h00, 0);
    check("bad idx ack", last_ack, 8'hE2);
    check("bad idx pg", pg_reset, 1'b0);

    cmd = '{8'h7F};
    send_cmd(cmd, 8'h00, 5);
    check("unknown ack", last_ack, 8'hE1);

    cmd = '{8'h03, 8'h78, 8'h56, 8'h34, 8'h12};
    send_cmd(cmd, 8'h00, 0);
    check("outer value", outer_period, 32'h12345678);

    cmd = '{8'h04, 8'hA5};
    send_cmd(cmd, 8'h00, 2);
    check("state0 ack", last_ack, 8'hA4);

    cmd = '{8'h01, 8'hFE, 8'h67, 8'h45, 8'h23, 8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'hF3};
    send_cmd(cmd, 8'h00, 0);
    check("edge254 slot", eds[254*RW +: RW], 68'h3_89ABCDEF_01234567);

    cmd = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    send_cmd(cmd, 8'h00, 0);
    cmd = '{8'h06};
    send_cmd(cmd, 8'h00, 0);
    check("clear eds zero", |eds, 1'b0);
    check("clear ack", last_ack, 8'hA6);

    cmd = '{8'h01, 8'h07, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h11, 8'h0C};
    send_cmd(cmd, 8'h00, 0);
    cmd = '{8'h05};
    send_cmd(cmd, 8'h00, 0);

    // Abort a WRITE_PERIOD after two of its four payload bytes.
    in_data  = 8'h02;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'h11;
    @(negedge clk);
    in_data = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("mid rst pg_reset", pg_reset, 1'b1);
    check("mid rst period", period, 32'd1);
    check("mid rst eds zero", |eds, 1'b0);
    repeat (4) @(negedge clk);

    cmd = '{8'h02, 8'hEF, 8'hBE, 8'h00, 8'h00};
    send_cmd(cmd, 8'h00, 0);
    check("post rst period", period, 32'h0000BEEF);

`ifdef EDGE_LOADER_CHECKSUM_EN
    cmd = '{8'h04, 8'h5A};
    send_cmd(cmd, 8'h00, 0);
    check("csum good state0", state0, 8'h5A);
    send_cmd(cmd, 8'h5E, 0);
    check("csum bad ack", last_ack, 8'hE3);
    cmd = '{8'h04, 8'h33};
    send_cmd(cmd, 8'h01, 0);
    check("csum bad state0", state0, 8'h5A);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
